zap_wb_mem_responder: RTL and testbench
=======================================

ZAP_WB_MEM_RESPONDER -- requirements
Module: zap_wb_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words of storage; it must be a power of 2 and at least 2.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning the number of extra cycles before acknowledge; range 0..15.
REQ-003 Port i_clk, input, 1 bit: core clock; all state changes on its rising edge.
REQ-004 Port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port i_wb_cyc, input, 1 bit: Wishbone cycle valid.
REQ-006 Port i_wb_stb, input, 1 bit: Wishbone strobe.
REQ-007 Port i_wb_wen, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port i_wb_sel, input, 4 bits: byte-lane enables; bit n selects bits 8n+7:8n.
REQ-009 Port i_wb_adr, input, 32 bits: byte address; bits 1:0 are ignored.
REQ-010 Port i_wb_dat, input, 32 bits: write data.
REQ-011 Port o_wb_dat, output, 32 bits: registered read data.
REQ-012 Port o_wb_ack, output, 1 bit: registered acknowledge.
REQ-013 Port o_wb_err, output, 1 bit: registered error; present only when ZAP_WB_ERR_EN is defined.

Function
REQ-014 The block SHALL be a Wishbone classic-cycle responder, the target end of the page-table-walk and cache-fill initiators.
REQ-015 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 In IDLE, when i_wb_cyc & i_wb_stb is sampled high, the block SHALL latch adr/wen/sel/dat and load the wait counter with WAIT_STATES.
- Next state: WAIT if WAIT_STATES > 0, else RESP.
REQ-017 In WAIT, the counter SHALL decrement each cycle.
- The block SHALL move to RESP on the edge where the counter is 1.
REQ-018 On the edge that enters RESP, the block SHALL do the following:
- Perform the write: only the lanes set in the latched sel change; sel = 0 writes nothing but still acknowledges.
- Or, for a read, register mem[word] into o_wb_dat for all lanes regardless of sel.
REQ-019 In RESP, o_wb_ack SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be exactly WAIT_STATES+1 cycles from the sampling edge to ack high.
- WAIT_STATES = 0 gives ack in the cycle immediately after the request is sampled.
REQ-021 A new request SHALL be sampled only in IDLE, so there is a minimum of one IDLE cycle between consecutive acks.
REQ-022 If i_wb_cyc or i_wb_stb is low at any edge in WAIT, the block SHALL abort: return to IDLE with no write, no ack and o_wb_dat unchanged.
REQ-023 Word index SHALL be i_wb_adr[log2(DEPTH)+1:2].
REQ-024 o_wb_dat SHALL hold its value except on a read entering RESP; writes never change it.
REQ-025 o_wb_ack (and o_wb_err) SHALL never be high while the state is IDLE or WAIT.

Reset
REQ-026 Asserting i_reset_n low SHALL immediately force the following, in any state, including mid-WAIT or in RESP:
- state = IDLE, counter = 0
- o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 32'h0
REQ-027 A transaction interrupted by reset SHALL be dropped: no write occurs, and no ack is issued after release.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 With ZAP_WB_ERR_EN defined, the block SHALL check i_wb_adr[31:log2(DEPTH)+2] at sampling; if that field is nonzero:
- the access proceeds through WAIT to RESP;
- in RESP, o_wb_err = 1 and o_wb_ack = 0;
- no write occurs and o_wb_dat is unchanged.
REQ-030 Without ZAP_WB_ERR_EN, the o_wb_err port SHALL be absent and upper address bits SHALL be ignored, so addresses alias modulo DEPTH words.

Verification
REQ-031 WAIT_STATES=2: write 32'hDEADBEEF, sel=4'hF, adr=32'h10, then read adr=32'h10 -> ack exactly 3 cycles after each sampling edge; o_wb_dat=32'hDEADBEEF.
REQ-032 Byte lanes: mem[4]=32'h11223344, then write 32'hAABBCCDD with sel=4'b0101 to adr=32'h10 -> read returns 32'h11BB33DD.
REQ-033 WAIT_STATES=0: read adr=32'h0 -> ack high in the cycle after sampling, held one cycle, then one IDLE cycle before the next request is sampled.
REQ-034 Abort: start a write of 32'h0 to adr=32'h10 (holding 32'h12345678), drop i_wb_cyc during WAIT -> no ack; a subsequent read returns 32'h12345678.
REQ-035 Reset mid-WAIT: assert i_reset_n=0 asynchronously -> o_wb_ack=0 and o_wb_dat=0 without a clock edge; no ack after release; memory is retained.
REQ-036 With ZAP_WB_ERR_EN, DEPTH=1024: read adr=32'h0000_1000 -> o_wb_err=1, o_wb_ack=0 for one cycle; without the macro, the same access acks with data from word 0.

Source files
------------

// File: rtl/zap_wb_mem_responder_if.sv
// ---------------------------------------------------------------------------
// zap_wb_mem_responder_if
//
// Wishbone classic-cycle bus between an initiator (page-table walker or cache
// fill engine) and the zap_wb_mem_responder memory target.
//
// Signals (named from the target's point of view):
//   i_wb_cyc  - cycle valid
//   i_wb_stb  - strobe
//   i_wb_wen  - 1 = write, 0 = read
//   i_wb_sel  - byte-lane enables, bit n covers data bits 8n+7:8n
//   i_wb_adr  - byte address (bits 1:0 ignored)
//   i_wb_dat  - write data
//   o_wb_dat  - registered read data
//   o_wb_ack  - registered acknowledge
//   o_wb_err  - registered error, only when ZAP_WB_ERR_EN is defined
//
// Modports: master (initiator side), slave (target side).
// ---------------------------------------------------------------------------
interface zap_wb_mem_responder_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_wen;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
`ifdef ZAP_WB_ERR_EN
    logic        o_wb_err;
`endif

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat,
        input  o_wb_dat, o_wb_ack
`ifdef ZAP_WB_ERR_EN
        , input o_wb_err
`endif
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_wen, i_wb_sel, i_wb_adr, i_wb_dat,
        output o_wb_dat, o_wb_ack
`ifdef ZAP_WB_ERR_EN
        , output o_wb_err
`endif
    );
endinterface

// File: rtl/zap_wb_mem_responder.sv
// ---------------------------------------------------------------------------
// zap_wb_mem_responder
//
// Wishbone classic-cycle memory target. A request is sampled in IDLE, waits
// WAIT_STATES cycles in WAIT, and is answered in RESP with a one-cycle ack
// (latency WAIT_STATES+1 from the sampling edge). Writes honour byte lanes;
// reads return the whole word. Dropping cyc/stb during WAIT aborts the access.
//
// Parameters:
//   DEPTH       - number of 32-bit words (power of 2, >= 2)
//   WAIT_STATES - extra cycles before acknowledge (0..15)
//
// Ports:
//   i_clk     - core clock, rising edge
//   i_reset_n - asynchronous active-low reset (memory contents are kept)
//   bus       - zap_wb_mem_responder_if.slave
//
// Optional feature: define ZAP_WB_ERR_EN to add o_wb_err. Accesses with any
// address bit set above the memory range then finish with err instead of ack
// and never write. Without it the upper address bits alias.
// ---------------------------------------------------------------------------
module zap_wb_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    zap_wb_mem_responder_if.slave         bus
);
    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wen_q, wen_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            err_q, err_d;
    logic            ack_q, ack_d;
    logic            oerr_q, oerr_d;
    logic [31:0]     rdat_q, rdat_d;

    logic            req;
    logic            addr_bad;
    logic [AW-1:0]   cur_idx;
    logic            cur_wen;
    logic [3:0]      cur_sel;
    logic [31:0]     cur_dat;
    logic            cur_err;
    logic [3:0]      lane_we;
    logic [7:0]      lane_rd [4];

    assign req = bus.i_wb_cyc & bus.i_wb_stb;

`ifdef ZAP_WB_ERR_EN
    assign addr_bad = |bus.i_wb_adr[31:AW+2];
    logic unused_adr;
    assign unused_adr = ^bus.i_wb_adr[1:0];
`else
    assign addr_bad = 1'b0;
    logic unused_adr;
    assign unused_adr = ^{bus.i_wb_adr[1:0], bus.i_wb_adr[31:AW+2], oerr_q};
`endif

    // Fields of the access being served. In IDLE they come straight off the
    // bus so that WAIT_STATES = 0 can complete on the sampling edge itself.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_idx = bus.i_wb_adr[AW+1:2];
            cur_wen = bus.i_wb_wen;
            cur_sel = bus.i_wb_sel;
            cur_dat = bus.i_wb_dat;
            cur_err = addr_bad;
        end else begin
            cur_idx = idx_q;
            cur_wen = wen_q;
            cur_sel = sel_q;
            cur_dat = wdat_q;
            cur_err = err_q;
        end
    end

    always_comb begin
        logic enter_resp;
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wen_d      = wen_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        err_d      = err_q;
        ack_d      = 1'b0;
        oerr_d     = 1'b0;
        rdat_d     = rdat_q;
        lane_we    = 4'b0;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = cur_idx;
                    wen_d  = cur_wen;
                    sel_d  = cur_sel;
                    wdat_d = cur_dat;
                    err_d  = cur_err;
                    if (WS == 4'd0) begin
                        state_d    = S_RESP;
                        cnt_d      = 4'd0;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            S_WAIT: begin
                // Abort wins over completion on the same edge.
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_resp) begin
            if (cur_err) begin
                oerr_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (cur_wen) lane_we = cur_sel;
                else         rdat_d  = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            sel_q   <= 4'b0;
            wdat_q  <= 32'h0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            oerr_q  <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            oerr_q  <= oerr_d;
            rdat_q  <= rdat_d;
        end
    end

    // One byte-wide array per lane gives natural byte-enable writes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            always_ff @(posedge i_clk) begin
                if (lane_we[gi]) lane_mem[cur_idx] <= cur_dat[8*gi +: 8];
            end
            assign lane_rd[gi] = lane_mem[cur_idx];
        end
    endgenerate

    assign bus.o_wb_dat = rdat_q;
    assign bus.o_wb_ack = ack_q;
`ifdef ZAP_WB_ERR_EN
    assign bus.o_wb_err = oerr_q;
`endif
endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_zap_wb_mem_responder
//
// Two responders side by side: index 0 with WAIT_STATES = 0, index 1 with
// WAIT_STATES = 2, both DEPTH = 1024. Directed transactions push their
// expected response into a per-DUT queue; a monitor pops and compares on
// every ack/err. Latency, abort, reset and back-to-back spacing are checked
// by the stimulus itself. Honours ZAP_WB_ERR_EN if defined.
// ---------------------------------------------------------------------------
module tb_zap_wb_mem_responder;
`ifdef ZAP_WB_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dat;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;

    logic        cyc  [2];
    logic        stb  [2];
    logic        wen  [2];
    logic [3:0]  sel  [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic        ack  [2];
    logic        err  [2];
    logic [31:0] rdat [2];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t q0[$];
    exp_t q1[$];

    zap_wb_mem_responder_if bus_ws0 ();
    zap_wb_mem_responder_if bus_ws2 ();

    assign bus_ws0.i_wb_cyc = cyc[0];
    assign bus_ws0.i_wb_stb = stb[0];
    assign bus_ws0.i_wb_wen = wen[0];
    assign bus_ws0.i_wb_sel = sel[0];
    assign bus_ws0.i_wb_adr = adr[0];
    assign bus_ws0.i_wb_dat = wdat[0];
    assign ack[0]  = bus_ws0.o_wb_ack;
    assign rdat[0] = bus_ws0.o_wb_dat;

    assign bus_ws2.i_wb_cyc = cyc[1];
    assign bus_ws2.i_wb_stb = stb[1];
    assign bus_ws2.i_wb_wen = wen[1];
    assign bus_ws2.i_wb_sel = sel[1];
    assign bus_ws2.i_wb_adr = adr[1];
    assign bus_ws2.i_wb_dat = wdat[1];
    assign ack[1]  = bus_ws2.o_wb_ack;
    assign rdat[1] = bus_ws2.o_wb_dat;

`ifdef ZAP_WB_ERR_EN
    assign err[0] = bus_ws0.o_wb_err;
    assign err[1] = bus_ws2.o_wb_err;
`else
    assign err[0] = 1'b0;
    assign err[1] = 1'b0;
`endif

    zap_wb_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_ws0)
    );

    zap_wb_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_ws2 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_ws2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Scoreboard monitor: every ack/err must match the oldest expectation.
    initial begin
        logic prev_resp [2];
        exp_t e;
        bit   have;
        prev_resp[0] = 1'b0;
        prev_resp[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                    check($sformatf("ws%0d_pulse_width", ws_of(d)), {31'b0, prev_resp[d]}, 32'h0);
                    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    if (!have) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ws%0d_unexpected_response: got ack=%0b err=%0b, expected none",
                                 ws_of(d), ack[d], err[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        $display("[TB] ws%0d %s ack=%0b err=%0b dat=%h", ws_of(d), e.tag, ack[d], err[d], rdat[d]);
                        check({e.tag, "_kind"}, {30'b0, ack[d], err[d]}, e.err ? 32'h1 : 32'h2);
                        if (e.chk && !e.err) check({e.tag, "_data"}, rdat[d], e.dat);
                    end
                    prev_resp[d] = 1'b1;
                end else begin
                    prev_resp[d] = 1'b0;
                end
            end
        end
    end

    task automatic txn(input int d, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_dat, input string tag);
        exp_t e;
        int   n;
        bit   got;
        e.err = ERR_BUILD && (a[31:12] != 20'h0);
        e.chk = !w;
        e.dat = exp_dat;
        e.tag = tag;
        push_exp(d, e);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; wen[d] = w; sel[d] = s; adr[d] = a; wdat[d] = wd;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = (ack[d] === 1'b1) || (err[d] === 1'b1);
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        check({tag, "_latency"}, n, ws_of(d) + 1);
        @(negedge clk);
    endtask

    task automatic expect_silence(input int d, input int cycles, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ack[d] === 1'b1 || err[d] === 1'b1) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pattern;
        exp_t       e;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; wen[d] = 1'b0;
            sel[d] = 4'h0; adr[d] = 32'h0; wdat[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ws%0d_reset_ack", ws_of(d)), {31'b0, ack[d]}, 32'h0);
            check($sformatf("ws%0d_reset_dat", ws_of(d)), rdat[d], 32'h0);
        end

        // Basic write/read with two wait states.
        txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        "wr_deadbeef");
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0,        32'hDEADBEEF, "rd_deadbeef");

        // Byte lanes; writes must not disturb o_wb_dat.
        txn(1, 1'b1, 4'hF,    32'h10, 32'h11223344, 32'h0, "wr_base");
        txn(1, 1'b1, 4'b0101, 32'h10, 32'hAABBCCDD, 32'h0, "wr_lanes");
        check("dat_held_over_writes", rdat[1], 32'hDEADBEEF);
        txn(1, 1'b0, 4'h0, 32'h10, 32'h0, 32'h11BB33DD, "rd_lanes");

        // sel = 0 acknowledges but writes nothing.
        txn(1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0,        "wr_sel0");
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0,        32'h11BB33DD, "rd_after_sel0");

        // Abort: drop cyc during WAIT.
        txn(1, 1'b1, 4'hF, 32'h10, 32'h12345678, 32'h0, "wr_12345678");
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h10; wdat[1] = 32'h0;
        @(negedge clk);
        cyc[1] = 1'b0;
        @(negedge clk);
        stb[1] = 1'b0;
        expect_silence(1, 6, "abort_no_ack");
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h12345678, "rd_after_abort");

        // Upper address bits: alias to word 0, or error when enabled.
        txn(1, 1'b1, 4'hF, 32'h0,         32'hA5A50000, 32'h0,        "wr_word0");
        txn(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0,        32'hA5A50000, "rd_alias_1000");

        // Zero wait states.
        txn(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0,        "wr_w0");
        txn(0, 1'b0, 4'hF, 32'h0, 32'h0,        32'h0BADF00D, "rd_w0");
        txn(0, 1'b1, 4'hF, 32'h4, 32'h00000005, 32'h0,        "wr_w1");
        txn(0, 1'b0, 4'hF, 32'h4, 32'h0,        32'h00000005, "rd_w1");

        // Request held continuously: ack, idle, ack, idle.
        e.err = 1'b0; e.chk = 1'b1; e.dat = 32'h0BADF00D; e.tag = "b2b_first";
        push_exp(0, e);
        e.tag = "b2b_second";
        push_exp(0, e);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; wen[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pattern[i] = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        check("b2b_ack_pattern", {28'b0, pattern}, 32'h5);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; wen[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'h10; wdat[1] = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ack", {31'b0, ack[1]}, 32'h0);
        check("async_reset_dat_ws2", rdat[1], 32'h0);
        check("async_reset_dat_ws0", rdat[0], 32'h0);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_silence(1, 6, "no_ack_after_reset");
        txn(1, 1'b0, 4'hF, 32'h10, 32'h0, 32'h12345678, "rd_retained_ws2");
        txn(0, 1'b0, 4'hF, 32'h4,  32'h0, 32'h00000005, "rd_retained_ws0");

        check("ws0_queue_drained", q0.size(), 32'h0);
        check("ws2_queue_drained", q1.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
